spi_seq: RTL and testbench

SPI_SEQ -- requirements
Module: spi_seq

---
 rtl/spi_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_seq.sv
`default_nettype none
// ============================================================================
//  Module   : spi_seq
//  Purpose  : Sequencer that drives a hard SPI controller over its SB_SPI
//             register bus. After reset it programs SPICR0/1/2 and SPIBR,
//             then moves bytes one at a time: optional chip-select assert,
//             poll TRDY, write TXDR, poll RRDY, read RXDR, optional CS release.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             tx_valid/tx_data/tx_last/tx_ready - byte request handshake
//             cs_sel              - chip select for a new frame (0=CS0, 1=CS1)
//             rx_valid/rx_data    - received byte, one-cycle pulse
//             init_done, err      - config complete, poll-timeout pulse
//             sb_stb/sb_rw/sb_adr/sb_dato/sb_acki/sb_dati - bus master port
//  Options  : define SPI_SEQ_TIMEOUT_EN to abort a poll after 1024 reads
//             with the flag still clear; otherwise polling never gives up.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_seq #(
  parameter logic [5:0] BR_DIV = 6'd2,
  parameter logic       CPOL   = 1'b0,
  parameter logic       CPHA   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       cs_sel,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       init_done,
  output logic       err,
  output logic       sb_stb,
  output logic       sb_rw,
  output logic [7:0] sb_adr,
  output logic [7:0] sb_dato,
  input  logic       sb_acki,
  input  logic [7:0] sb_dati
);

  localparam logic [7:0] ADR_CR0  = 8'h08;
  localparam logic [7:0] ADR_CR1  = 8'h09;
  localparam logic [7:0] ADR_CR2  = 8'h0A;
  localparam logic [7:0] ADR_BR   = 8'h0B;
  localparam logic [7:0] ADR_SR   = 8'h0C;
  localparam logic [7:0] ADR_TXDR = 8'h0D;
  localparam logic [7:0] ADR_RXDR = 8'h0E;
  localparam logic [7:0] ADR_CSR  = 8'h0F;

  typedef enum logic [3:0] {
    INIT_CR0  = 4'd0,
    INIT_CR1  = 4'd1,
    INIT_CR2  = 4'd2,
    INIT_BR   = 4'd3,
    IDLE      = 4'd4,
    CS_ON     = 4'd5,
    POLL_TRDY = 4'd6,
    WR_TX     = 4'd7,
    POLL_RRDY = 4'd8,
    RD_RX     = 4'd9,
    CS_OFF    = 4'd10
  } state_t;

  state_t     state;
  logic       frame_open;
  logic       last_q;
  logic       cs_q;
  logic [7:0] byte_q;

  // Bus command implied by the current state; launched when sb_stb is low.
  logic       cmd_rw;
  logic [7:0] cmd_adr;
  logic [7:0] cmd_dat;

  always_comb begin
    cmd_rw  = 1'b0;
    cmd_adr = 8'h00;
    cmd_dat = 8'h00;
    case (state)
      INIT_CR0:  begin cmd_rw = 1'b1; cmd_adr = ADR_CR0; cmd_dat = 8'h00; end
      INIT_CR1:  begin cmd_rw = 1'b1; cmd_adr = ADR_CR1; cmd_dat = 8'h80; end
      INIT_CR2:  begin
        cmd_rw  = 1'b1;
        cmd_adr = ADR_CR2;
        cmd_dat = {1'b1, 1'b1, 3'b000, CPOL, CPHA, 1'b0};
      end
      INIT_BR:   begin cmd_rw = 1'b1; cmd_adr = ADR_BR;  cmd_dat = {2'b00, BR_DIV}; end
      CS_ON:     begin
        cmd_rw  = 1'b1;
        cmd_adr = ADR_CSR;
        cmd_dat = cs_q ? 8'h02 : 8'h01;
      end
      POLL_TRDY: begin cmd_rw = 1'b0; cmd_adr = ADR_SR; end
      WR_TX:     begin cmd_rw = 1'b1; cmd_adr = ADR_TXDR; cmd_dat = byte_q; end
      POLL_RRDY: begin cmd_rw = 1'b0; cmd_adr = ADR_SR; end
      RD_RX:     begin cmd_rw = 1'b0; cmd_adr = ADR_RXDR; end
      CS_OFF:    begin cmd_rw = 1'b1; cmd_adr = ADR_CSR; cmd_dat = 8'h00; end
      default:   begin cmd_rw = 1'b0; cmd_adr = 8'h00; cmd_dat = 8'h00; end
    endcase
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [9:0] poll_cnt;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Each bus state launches one cycle when sb_stb is low and advances on the
  // ack. Because the ack edge also clears sb_stb, the next state's launch
  // edge is one cycle later, which gives the mandatory idle gap for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT_CR0;
      sb_stb     <= 1'b0;
      sb_rw      <= 1'b0;
      sb_adr     <= 8'h00;
      sb_dato    <= 8'h00;
      tx_ready   <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      init_done  <= 1'b0;
      frame_open <= 1'b0;
      last_q     <= 1'b0;
      cs_q       <= 1'b0;
      byte_q     <= 8'h00;
`ifdef SPI_SEQ_TIMEOUT_EN
      poll_cnt   <= 10'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      if (state == IDLE) begin
        if (tx_ready && tx_valid) begin
          tx_ready <= 1'b0;
          byte_q   <= tx_data;
          last_q   <= tx_last;
          cs_q     <= cs_sel;
          state    <= frame_open ? POLL_TRDY : CS_ON;
        end else begin
          // Entering IDLE leaves tx_ready low for one cycle, so it never
          // coincides with the rx_valid pulse.
          tx_ready <= init_done;
        end
      end else if (!sb_stb) begin
        sb_stb  <= 1'b1;
        sb_rw   <= cmd_rw;
        sb_adr  <= cmd_adr;
        sb_dato <= cmd_dat;
      end else if (sb_acki) begin
        sb_stb <= 1'b0;
        case (state)
          INIT_CR0: state <= INIT_CR1;
          INIT_CR1: state <= INIT_CR2;
          INIT_CR2: state <= INIT_BR;
          INIT_BR: begin
            init_done <= 1'b1;
            state     <= IDLE;
          end
          CS_ON: begin
            frame_open <= 1'b1;
            state      <= POLL_TRDY;
          end
          POLL_TRDY: begin
            if (sb_dati[4]) begin
              state <= WR_TX;
`ifdef SPI_SEQ_TIMEOUT_EN
              poll_cnt <= 10'd0;
`endif
            end
`ifdef SPI_SEQ_TIMEOUT_EN
            else if (poll_cnt == 10'd1023) begin
              poll_cnt <= 10'd0;
              err_q    <= 1'b1;
              state    <= CS_OFF;
            end else begin
              poll_cnt <= poll_cnt + 10'd1;
            end
`endif
          end
          WR_TX: state <= POLL_RRDY;
          POLL_RRDY: begin
            if (sb_dati[3]) begin
              state <= RD_RX;
`ifdef SPI_SEQ_TIMEOUT_EN
              poll_cnt <= 10'd0;
`endif
            end
`ifdef SPI_SEQ_TIMEOUT_EN
            else if (poll_cnt == 10'd1023) begin
              poll_cnt <= 10'd0;
              err_q    <= 1'b1;
              state    <= CS_OFF;
            end else begin
              poll_cnt <= poll_cnt + 10'd1;
            end
`endif
          end
          RD_RX: begin
            rx_valid <= 1'b1;
            rx_data  <= sb_dati;
            state    <= last_q ? CS_OFF : IDLE;
          end
          CS_OFF: begin
            frame_open <= 1'b0;
            state      <= IDLE;
          end
          default: state <= INIT_CR0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_seq
//  Purpose  : Directed self-checking bench for spi_seq with a SB_SPI bus
//             model that acks one cycle after sb_stb rises.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic       cs_sel = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       init_done;
  logic       err;
  logic       sb_stb;
  logic       sb_rw;
  logic [7:0] sb_adr;
  logic [7:0] sb_dato;
  logic       sb_acki = 1'b0;
  logic [7:0] sb_dati = 8'h00;

  spi_seq dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .cs_sel(cs_sel),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .init_done(init_done), .err(err),
    .sb_stb(sb_stb), .sb_rw(sb_rw), .sb_adr(sb_adr), .sb_dato(sb_dato),
    .sb_acki(sb_acki), .sb_dati(sb_dati)
  );

  always #5 clk = ~clk;

  // Bus model state (written only by the model process)
  logic [15:0] wr_q[$];
  int          sr_reads  = 0;
  int          tx_total  = 0;
  int          sr_at_tx  = 0;
  int          rx_at_tx  = 0;
  // Bus model configuration (written only by the stimulus process)
  bit          sr_stuck   = 1'b0;
  int          zero_until = 0;
  bit          split_mode = 1'b0;
  int          tx_mark    = 0;
  logic [7:0]  rx_byte    = 8'h3C;
  // Output monitor state
  int          rx_cnt  = 0;
  logic [7:0]  rx_last = 8'h00;
  int          err_cnt = 0;

  int n_cmp = 0;
  int n_mis = 0;

  always @(posedge clk) begin
    if (sb_stb && !sb_acki) begin
      sb_acki <= 1'b1;
      if (sb_rw) begin
        wr_q.push_back({sb_adr, sb_dato});
        if (sb_adr == 8'h0D) begin
          tx_total = tx_total + 1;
          sr_at_tx = sr_reads;
          rx_at_tx = rx_cnt;
        end
      end else if (sb_adr == 8'h0C) begin
        if (sr_stuck || sr_reads < zero_until) sb_dati <= 8'h00;
        else if (split_mode) sb_dati <= (tx_total > tx_mark) ? 8'h08 : 8'h10;
        else sb_dati <= 8'h18;
        sr_reads = sr_reads + 1;
      end else if (sb_adr == 8'h0E) begin
        sb_dati <= rx_byte;
      end else begin
        sb_dati <= 8'h00;
      end
    end else begin
      sb_acki <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt  = rx_cnt + 1;
      rx_last = rx_data;
    end
    if (err) err_cnt = err_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = tx_ready;
    end
    if (!ok) check_val("tmo_ready", 0, 1);
  endtask

  task automatic wait_init(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = init_done;
    end
    if (!ok) check_val("tmo_init", 0, 1);
  endtask

  task automatic wait_rx(input int target, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (rx_cnt >= target);
    end
    if (!ok) check_val("tmo_rx", 0, 1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic c);
    wait_ready(3000);
    tx_data  = d;
    tx_last  = l;
    cs_sel   = c;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  function automatic logic [15:0] wr_at(input int idx);
    if (idx < wr_q.size()) return wr_q[idx];
    return 16'hFFFF;
  endfunction

  int base_w, base_rx, base_sr, base_err, csr_n;
  bit found;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_stb",       sb_stb,    0);
    check_val("rst_rw",        sb_rw,     0);
    check_val("rst_adr",       sb_adr,    8'h00);
    check_val("rst_dato",      sb_dato,   8'h00);
    check_val("rst_tx_ready",  tx_ready,  0);
    check_val("rst_rx_valid",  rx_valid,  0);
    check_val("rst_rx_data",   rx_data,   8'h00);
    check_val("rst_init_done", init_done, 0);
    check_val("rst_err",       err,       0);

    // Init sequence
    base_w = wr_q.size();
    rst = 1'b0;
    wait_init(200);
    check_val("init_nwr", wr_q.size() - base_w, 4);
    check_val("init_cr0", wr_at(base_w + 0), 16'h0800);
    check_val("init_cr1", wr_at(base_w + 1), 16'h0980);
    check_val("init_cr2", wr_at(base_w + 2), 16'h0AC0);
    check_val("init_br",  wr_at(base_w + 3), 16'h0B02);
    wait_ready(20);
    check_val("init_hold", init_done, 1);

    // Single byte frame on CS1
    base_w = wr_q.size(); base_rx = rx_cnt; base_sr = sr_reads;
    send_byte(8'hA5, 1'b1, 1'b1);
    wait_rx(base_rx + 1, 500);
    check_val("b1_rx_data", rx_last, 8'h3C);
    wait_ready(500);
    check_val("b1_nwr",  wr_q.size() - base_w, 3);
    check_val("b1_cson", wr_at(base_w + 0), 16'h0F02);
    check_val("b1_tx",   wr_at(base_w + 1), 16'h0DA5);
    check_val("b1_csof", wr_at(base_w + 2), 16'h0F00);
    check_val("b1_nsr",  sr_reads - base_sr, 2);
    check_val("b1_nrx",  rx_cnt - base_rx, 1);

    // Three byte frame, cs_sel toggled mid-frame
    base_w = wr_q.size(); base_rx = rx_cnt;
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b1);
    send_byte(8'h33, 1'b1, 1'b0);
    wait_rx(base_rx + 3, 500);
    wait_ready(500);
    csr_n = 0;
    for (int i = base_w; i < wr_q.size(); i++)
      if (wr_q[i][15:8] == 8'h0F) csr_n++;
    check_val("f3_ncsr", csr_n, 2);
    check_val("f3_nwr",  wr_q.size() - base_w, 5);
    check_val("f3_cson", wr_at(base_w + 0), 16'h0F01);
    check_val("f3_tx2",  wr_at(base_w + 2), 16'h0D22);
    check_val("f3_csof", wr_at(base_w + 4), 16'h0F00);
    check_val("f3_nrx",  rx_cnt - base_rx, 3);

    // TRDY slow to rise: five clear reads, then TRDY-only, then RRDY-only
    base_rx = rx_cnt; base_sr = sr_reads;
    zero_until = sr_reads + 5;
    tx_mark    = tx_total;
    split_mode = 1'b1;
    rx_byte    = 8'h5A;
    send_byte(8'hC3, 1'b1, 1'b0);
    wait_rx(base_rx + 1, 500);
    wait_ready(500);
    check_val("poll_sr_before_tx", sr_at_tx - base_sr, 6);
    check_val("poll_rx_before_tx", rx_at_tx - base_rx, 0);
    check_val("poll_nsr",          sr_reads - base_sr, 7);
    check_val("poll_rx_data",      rx_last, 8'h5A);
    split_mode = 1'b0;

`ifdef SPI_SEQ_TIMEOUT_EN
    // SPISR stuck at zero: poll gives up after 1024 reads
    base_rx = rx_cnt; base_sr = sr_reads; base_err = err_cnt;
    sr_stuck = 1'b1;
    send_byte(8'h77, 1'b0, 1'b0);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 6000 && !ok; i++) begin
        @(negedge clk);
        ok = (err_cnt > base_err);
      end
      if (!ok) check_val("tmo_err", 0, 1);
    end
    check_val("to_nsr", sr_reads - base_sr, 1024);
    wait_ready(200);
    sr_stuck = 1'b0;
    check_val("to_nerr", err_cnt - base_err, 1);
    check_val("to_csof", wr_at(wr_q.size() - 1), 16'h0F00);
    check_val("to_nrx",  rx_cnt - base_rx, 0);
`endif

    // Reset while the TXDR write is on the bus
    send_byte(8'h99, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      found = sb_stb && sb_rw && (sb_adr == 8'h0D);
    end
    if (!found) check_val("tmo_wrtx", 0, 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("mrst_stb",   sb_stb,    0);
    check_val("mrst_init",  init_done, 0);
    check_val("mrst_ready", tx_ready,  0);
    @(negedge clk);
    base_w = wr_q.size();
    rst = 1'b0;
    wait_init(200);
    check_val("mrst_nwr", wr_q.size() - base_w, 4);
    check_val("mrst_cr0", wr_at(base_w), 16'h0800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
